// File: rtl/huffman_bitstream_decoder.sv
// huffman_bitstream_decoder
//   MSB-first bitstream engine for the inflate datapath. Input words are packed
//   into a left-aligned shift buffer. One command at a time is executed:
//   lit/dist Huffman symbol decode (via external combinational tables), raw
//   extra-bit extraction, or byte align.
//
// Ports
//   clk, rst                        clock, synchronous active-high reset
//   data_in_vld/data_in/data_in_rdy input word stream (bit IN_W-1 first)
//   cmd_vld/cmd_op/cmd_nbits/cmd_rdy command handshake
//                                   (op 0 lit, 1 dist, 2 raw, 3 align)
//   huff_addr                       top HUFF_CODE_LEN buffered bits, drives both tables
//   lit_huff_len/lit_huff_sym       lit table response (len 0 = invalid code)
//   dist_huff_len/dist_huff_sym     dist table response (len 0 = invalid code)
//   data_out_vld/data_out/data_out_err/data_out_rdy  result handshake
//   err                             sticky invalid-code flag
module huffman_bitstream_decoder #(
  parameter int IN_W          = 8,
  parameter int BUF_W         = 32,
  parameter int HUFF_CODE_LEN = 15,
  parameter int HUFF_LEN_LEN  = $clog2(HUFF_CODE_LEN + 1),
  parameter int SYM_W         = 9,
  parameter int RAW_W         = 13,
  parameter int OUT_W         = 13,
  localparam int NB_W         = $clog2(RAW_W + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     data_in_vld,
  input  logic [IN_W-1:0]          data_in,
  output logic                     data_in_rdy,
  input  logic                     cmd_vld,
  input  logic [1:0]               cmd_op,
  input  logic [NB_W-1:0]          cmd_nbits,
  output logic                     cmd_rdy,
  output logic [HUFF_CODE_LEN-1:0] huff_addr,
  input  logic [HUFF_LEN_LEN-1:0]  lit_huff_len,
  input  logic [SYM_W-1:0]         lit_huff_sym,
  input  logic [HUFF_LEN_LEN-1:0]  dist_huff_len,
  input  logic [SYM_W-1:0]         dist_huff_sym,
  output logic                     data_out_vld,
  output logic [OUT_W-1:0]         data_out,
  output logic                     data_out_err,
  input  logic                     data_out_rdy,
  output logic                     err
);

  localparam int FC_W = $clog2(BUF_W + 1);

  localparam logic [1:0] OP_LIT   = 2'd0;
  localparam logic [1:0] OP_DIST  = 2'd1;
  localparam logic [1:0] OP_RAW   = 2'd2;

  typedef enum logic [1:0] {IDLE, EXEC, OUT} state_t;

  state_t             state;
  logic [1:0]         op_q;
  logic [NB_W-1:0]    nbits_q;
  logic [BUF_W-1:0]   buffer;
  logic [FC_W-1:0]    fill_cnt;

  logic [HUFF_LEN_LEN-1:0] sel_len;
  logic [SYM_W-1:0]        sel_sym;
  logic                    resolve;
  logic                    res_err;
  logic [FC_W-1:0]         consume;
  logic [OUT_W-1:0]        res_val;
  logic                    in_fire;
  logic [FC_W-1:0]         fill_next;
  logic [BUF_W-1:0]        buffer_next;

  // Raw counts above RAW_W cannot be represented in data_out; clamp them.
  function automatic logic [NB_W-1:0] sat_nbits(input logic [NB_W-1:0] n);
    if (32'(n) > RAW_W) return NB_W'(RAW_W);
    return n;
  endfunction

  // Top n bits of the buffer, right-justified; n = 0 yields 0.
  function automatic logic [OUT_W-1:0] top_bits(input logic [BUF_W-1:0] b,
                                                input logic [NB_W-1:0]  n);
    logic [BUF_W-1:0] s;
    if (n == '0) return '0;
    s = b >> (BUF_W - int'(n));
    return s[OUT_W-1:0];
  endfunction

  assign huff_addr = buffer[BUF_W-1 -: HUFF_CODE_LEN];
  assign in_fire   = data_in_vld && data_in_rdy;

  // Command resolution: decides whether the latched op can complete this
  // cycle, what it returns and how many bits it consumes.
  always_comb begin
    sel_len = (op_q == OP_DIST) ? dist_huff_len : lit_huff_len;
    sel_sym = (op_q == OP_DIST) ? dist_huff_sym : lit_huff_sym;
    resolve = 1'b0;
    res_err = 1'b0;
    consume = '0;
    res_val = '0;
    if (state == EXEC) begin
      case (op_q)
        OP_LIT, OP_DIST: begin
          // Zero fill below the fill point leaves a short final code's
          // prefix lookup intact, so len <= fill_cnt is enough.
          if (sel_len != '0 && 32'(sel_len) <= 32'(fill_cnt)) begin
            resolve = 1'b1;
            consume = FC_W'(sel_len);
            res_val = OUT_W'(sel_sym);
          end else if (sel_len == '0 && 32'(fill_cnt) >= HUFF_CODE_LEN) begin
            // Only a full-width lookup can prove a code invalid.
            resolve = 1'b1;
            res_err = 1'b1;
          end
        end
        OP_RAW: begin
          if (32'(fill_cnt) >= 32'(nbits_q)) begin
            resolve = 1'b1;
            consume = FC_W'(nbits_q);
            res_val = top_bits(buffer, nbits_q);
          end
        end
        default: begin
          resolve = 1'b1;
          consume = FC_W'(fill_cnt[2:0]);
          res_val = OUT_W'(fill_cnt[2:0]);
        end
      endcase
    end
  end

  // Buffer update: consume from the top, append the new word just below the
  // remaining valid bits; both may happen in the same cycle.
  always_comb begin
    fill_next   = fill_cnt - consume;
    buffer_next = buffer << consume;
    if (in_fire) begin
      buffer_next = buffer_next |
                    ({data_in, {(BUF_W-IN_W){1'b0}}} >> (fill_cnt - consume));
      fill_next   = fill_next + FC_W'(IN_W);
    end
  end

  // Registered state, command FSM and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      op_q         <= OP_LIT;
      nbits_q      <= '0;
      buffer       <= '0;
      fill_cnt     <= '0;
      cmd_rdy      <= 1'b0;
      data_in_rdy  <= 1'b0;
      data_out_vld <= 1'b0;
      data_out     <= '0;
      data_out_err <= 1'b0;
      err          <= 1'b0;
    end else begin
      buffer      <= buffer_next;
      fill_cnt    <= fill_next;
      data_in_rdy <= (32'(fill_next) <= 32'(BUF_W - IN_W));
      case (state)
        IDLE: begin
          if (cmd_vld && cmd_rdy) begin
            op_q    <= cmd_op;
            nbits_q <= sat_nbits(cmd_nbits);
            cmd_rdy <= 1'b0;
            state   <= EXEC;
          end else begin
            cmd_rdy <= 1'b1;
          end
        end
        EXEC: begin
          if (resolve) begin
            data_out     <= res_val;
            data_out_err <= res_err;
            data_out_vld <= 1'b1;
            if (res_err) err <= 1'b1;
            state        <= OUT;
          end
        end
        OUT: begin
          if (data_out_rdy) begin
            data_out_vld <= 1'b0;
            cmd_rdy      <= 1'b1;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_huffman_bitstream_decoder.sv
module tb_huffman_bitstream_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        data_in_vld;
  logic [7:0]  data_in;
  logic        data_in_rdy;
  logic        cmd_vld;
  logic [1:0]  cmd_op;
  logic [3:0]  cmd_nbits;
  logic        cmd_rdy;
  logic [14:0] huff_addr;
  logic [3:0]  lit_huff_len;
  logic [8:0]  lit_huff_sym;
  logic [3:0]  dist_huff_len;
  logic [8:0]  dist_huff_sym;
  logic        data_out_vld;
  logic [12:0] data_out;
  logic        data_out_err;
  logic        data_out_rdy;
  logic        err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  huffman_bitstream_decoder dut (
    .clk(clk), .rst(rst),
    .data_in_vld(data_in_vld), .data_in(data_in), .data_in_rdy(data_in_rdy),
    .cmd_vld(cmd_vld), .cmd_op(cmd_op), .cmd_nbits(cmd_nbits), .cmd_rdy(cmd_rdy),
    .huff_addr(huff_addr),
    .lit_huff_len(lit_huff_len), .lit_huff_sym(lit_huff_sym),
    .dist_huff_len(dist_huff_len), .dist_huff_sym(dist_huff_sym),
    .data_out_vld(data_out_vld), .data_out(data_out), .data_out_err(data_out_err),
    .data_out_rdy(data_out_rdy), .err(err)
  );

  // Table model: prefixes 0, 10, 110 valid; 111 invalid in both tables.
  always_comb begin
    lit_huff_len  = 4'd0; lit_huff_sym  = 9'h000;
    dist_huff_len = 4'd0; dist_huff_sym = 9'h000;
    if (huff_addr[14] == 1'b0) begin
      lit_huff_len = 4'd1;  lit_huff_sym = 9'h001;
      dist_huff_len = 4'd1; dist_huff_sym = 9'h002;
    end else if (huff_addr[13] == 1'b0) begin
      lit_huff_len = 4'd2;  lit_huff_sym = 9'h0AA;
      dist_huff_len = 4'd2; dist_huff_sym = 9'h00B;
    end else if (huff_addr[12] == 1'b0) begin
      lit_huff_len = 4'd3;  lit_huff_sym = 9'h105;
      dist_huff_len = 4'd3; dist_huff_sym = 9'h017;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    tests++;
    fails++;
    $display("FAIL %s: timed out waiting, expected event within bound", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    int n;
    n = 0;
    while (!data_in_rdy && n < 50) begin tick(); n++; end
    if (!data_in_rdy) begin timeout_fail("push data_in_rdy"); return; end
    data_in = b;
    data_in_vld = 1'b1;
    tick();
    data_in_vld = 1'b0;
  endtask

  task automatic issue(input logic [1:0] op, input logic [3:0] nb);
    int n;
    n = 0;
    while (!cmd_rdy && n < 50) begin tick(); n++; end
    if (!cmd_rdy) begin timeout_fail("issue cmd_rdy"); return; end
    cmd_vld = 1'b1; cmd_op = op; cmd_nbits = nb;
    tick();
    cmd_vld = 1'b0;
  endtask

  // Called one cycle after the command fire edge; lat counts from that edge.
  task automatic wait_vld(output int lat, output logic ok);
    lat = 1;
    while (!data_out_vld && lat < 60) begin tick(); lat++; end
    ok = data_out_vld;
    if (!ok) timeout_fail("wait data_out_vld");
  endtask

  task automatic ack();
    data_out_rdy = 1'b1;
    tick();
    data_out_rdy = 1'b0;
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [3:0] nb,
                         output logic [12:0] dout, output logic derr, output int lat);
    logic ok;
    issue(op, nb);
    wait_vld(lat, ok);
    dout = ok ? data_out : 13'h1FFF;
    derr = ok ? data_out_err : 1'bx;
    if (ok) ack();
  endtask

  typedef struct {
    int         n_in;
    logic [7:0] in0;
    logic [7:0] in1;
    logic [1:0] op;
    logic [3:0] nb;
    logic [12:0] exp_out;
    logic       exp_oerr;
    int         exp_fill;
    logic       exp_sticky;
  } vec_t;

  vec_t vecs[17];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [12:0] dout;
    logic        derr;
    int          lat;
    logic        ok;
    int          bad;

    vecs[0]  = '{2, 8'hA5, 8'h3C, 2'd2, 4'd12, 13'hA53,  1'b0, 4,  1'b0};
    vecs[1]  = '{0, 8'h00, 8'h00, 2'd2, 4'd4,  13'h00C,  1'b0, 0,  1'b0};
    vecs[2]  = '{1, 8'hD0, 8'h00, 2'd0, 4'd0,  13'h105,  1'b0, 5,  1'b0};
    vecs[3]  = '{0, 8'h00, 8'h00, 2'd3, 4'd0,  13'h005,  1'b0, 0,  1'b0};
    vecs[4]  = '{1, 8'hD0, 8'h00, 2'd1, 4'd0,  13'h017,  1'b0, 5,  1'b0};
    vecs[5]  = '{0, 8'h00, 8'h00, 2'd3, 4'd0,  13'h005,  1'b0, 0,  1'b0};
    vecs[6]  = '{2, 8'hE0, 8'h00, 2'd0, 4'd0,  13'h000,  1'b1, 16, 1'b1};
    vecs[7]  = '{0, 8'h00, 8'h00, 2'd2, 4'd13, 13'h1C00, 1'b0, 3,  1'b1};
    vecs[8]  = '{0, 8'h00, 8'h00, 2'd3, 4'd0,  13'h003,  1'b0, 0,  1'b1};
    vecs[9]  = '{0, 8'h00, 8'h00, 2'd2, 4'd0,  13'h000,  1'b0, 0,  1'b1};
    vecs[10] = '{1, 8'h80, 8'h00, 2'd0, 4'd0,  13'h0AA,  1'b0, 6,  1'b1};
    vecs[11] = '{0, 8'h00, 8'h00, 2'd0, 4'd0,  13'h001,  1'b0, 5,  1'b1};
    vecs[12] = '{0, 8'h00, 8'h00, 2'd2, 4'd5,  13'h000,  1'b0, 0,  1'b1};
    vecs[13] = '{1, 8'h4B, 8'h00, 2'd2, 4'd3,  13'h002,  1'b0, 5,  1'b1};
    vecs[14] = '{0, 8'h00, 8'h00, 2'd2, 4'd5,  13'h00B,  1'b0, 0,  1'b1};
    vecs[15] = '{1, 8'h3E, 8'h00, 2'd2, 4'd6,  13'h00F,  1'b0, 2,  1'b1};
    vecs[16] = '{0, 8'h00, 8'h00, 2'd0, 4'd0,  13'h0AA,  1'b0, 0,  1'b1};

    rst = 1'b1; data_in_vld = 1'b0; data_in = '0; cmd_vld = 1'b0;
    cmd_op = '0; cmd_nbits = '0; data_out_rdy = 1'b0;
    repeat (3) tick();
    check("rst data_out_vld", 32'(data_out_vld), 0);
    check("rst cmd_rdy", 32'(cmd_rdy), 0);
    check("rst data_in_rdy", 32'(data_in_rdy), 0);
    check("rst err", 32'(err), 0);
    check("rst huff_addr", 32'(huff_addr), 0);
    check("rst data_out", 32'(data_out), 0);
    rst = 1'b0;
    tick();
    check("post-rst cmd_rdy", 32'(cmd_rdy), 1);
    check("post-rst data_in_rdy", 32'(data_in_rdy), 1);
    check("post-rst fill", 32'(dut.fill_cnt), 0);

    // Table-driven command sequence; buffer state carries over between rows.
    for (int i = 0; i < 17; i++) begin
      if (vecs[i].n_in > 0) push(vecs[i].in0);
      if (vecs[i].n_in > 1) push(vecs[i].in1);
      run_cmd(vecs[i].op, vecs[i].nb, dout, derr, lat);
      check($sformatf("v%0d data_out", i), 32'(dout), 32'(vecs[i].exp_out));
      check($sformatf("v%0d data_out_err", i), 32'(derr), 32'(vecs[i].exp_oerr));
      check($sformatf("v%0d fill_cnt", i), 32'(dut.fill_cnt), 32'(vecs[i].exp_fill));
      check($sformatf("v%0d err", i), 32'(err), 32'(vecs[i].exp_sticky));
      check($sformatf("v%0d latency", i), 32'(lat), 2);
    end

    // Valid code longer than available bits waits for input.
    issue(2'd1, 4'd0);
    bad = 0;
    repeat (3) begin if (data_out_vld) bad++; tick(); end
    check("dist wait on empty", 32'(bad), 0);
    push(8'h40);
    wait_vld(lat, ok);
    check("dist after fill", 32'(data_out), 32'h002);
    ack();
    check("dist fill", 32'(dut.fill_cnt), 7);
    run_cmd(2'd0, 4'd0, dout, derr, lat);
    check("lit 10 prefix", 32'(dout), 32'h0AA);
    run_cmd(2'd3, 4'd0, dout, derr, lat);
    check("align 5", 32'(dout), 5);

    // Invalid code is only reported once HUFF_CODE_LEN bits are present.
    push(8'hE0);
    issue(2'd0, 4'd0);
    bad = 0;
    repeat (4) begin if (data_out_vld) bad++; tick(); end
    check("invalid waits below 15 bits", 32'(bad), 0);
    push(8'h00);
    wait_vld(lat, ok);
    check("invalid data_out_err", 32'(data_out_err), 1);
    check("invalid data_out", 32'(data_out), 0);
    check("invalid fill", 32'(dut.fill_cnt), 16);
    ack();
    run_cmd(2'd2, 4'd13, dout, derr, lat);
    check("raw after error", 32'(dout), 32'h1C00);
    run_cmd(2'd3, 4'd0, dout, derr, lat);
    check("align 3", 32'(dout), 3);

    // Backpressure, full buffer and simultaneous fill/consume.
    push(8'h11); push(8'h22); push(8'h33);
    issue(2'd2, 4'd8);
    wait_vld(lat, ok);
    check("bp first result", 32'(data_out), 32'h11);
    push(8'h44); push(8'h55);
    check("bp full fill", 32'(dut.fill_cnt), 32);
    check("bp data_in_rdy low", 32'(data_in_rdy), 0);
    data_in = 8'h99; data_in_vld = 1'b1;
    bad = 0;
    repeat (8) begin
      if (!data_out_vld || data_out !== 13'h11 || data_in_rdy) bad++;
      tick();
    end
    data_in_vld = 1'b0;
    check("bp hold stable", 32'(bad), 0);
    check("bp full not overfilled", 32'(dut.fill_cnt), 32);
    ack();
    run_cmd(2'd2, 4'd8, dout, derr, lat);
    check("bp second result", 32'(dout), 32'h22);
    issue(2'd2, 4'd8);
    check("sim rdy", 32'(data_in_rdy), 1);
    data_in = 8'h66; data_in_vld = 1'b1;
    tick();
    data_in_vld = 1'b0;
    check("sim vld", 32'(data_out_vld), 1);
    check("sim result", 32'(data_out), 32'h33);
    check("sim fill", 32'(dut.fill_cnt), 24);
    ack();
    run_cmd(2'd2, 4'd8, dout, derr, lat);
    check("drain 44", 32'(dout), 32'h44);
    run_cmd(2'd2, 4'd8, dout, derr, lat);
    check("drain 55", 32'(dout), 32'h55);
    run_cmd(2'd2, 4'd8, dout, derr, lat);
    check("drain 66", 32'(dout), 32'h66);
    check("drain fill", 32'(dut.fill_cnt), 0);

    // Reset while a command is executing with 20 bits buffered.
    push(8'hAA); push(8'hBB); push(8'hCC);
    run_cmd(2'd2, 4'd4, dout, derr, lat);
    check("pre-rst raw", 32'(dout), 32'hA);
    issue(2'd0, 4'd0);
    check("pre-rst fill", 32'(dut.fill_cnt), 20);
    check("pre-rst err", 32'(err), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid-rst data_out_vld", 32'(data_out_vld), 0);
    check("mid-rst fill", 32'(dut.fill_cnt), 0);
    tick();
    check("after-rst cmd_rdy", 32'(cmd_rdy), 1);
    check("after-rst data_out_vld", 32'(data_out_vld), 0);
    check("after-rst data_in_rdy", 32'(data_in_rdy), 1);
    check("after-rst huff_addr", 32'(huff_addr), 0);
    check("after-rst err", 32'(err), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/huffman_bitstream_decoder.md
Name: huffman_bitstream_decoder

Overview:
Parametrised MSB-first bitstream engine for the inflate datapath; successor to the fixed 16-bit, 8-bit-input Huffman decoder.
- Buffers input words of IN_W bits in a BUF_W-bit shift buffer.
- Executes one command at a time: literal/length symbol decode, distance symbol decode, raw extra-bit extraction, or byte-align.
- Symbol lookup uses external combinational lit/dist tables addressed by the top HUFF_CODE_LEN buffered bits.
- Adds command handshake, raw-bit and align modes, simultaneous fill/consume, end-of-stream-safe short codes, and invalid-code error reporting.

Parameters:
IN_W, 8, input word width; must be a multiple of 8.
BUF_W, 32, bit buffer width; must be >= max(HUFF_CODE_LEN, RAW_W) + IN_W - 1.
HUFF_CODE_LEN, 15, maximum code length and table address width.
HUFF_LEN_LEN, ceilLog2(HUFF_CODE_LEN+1), width of the code-length field returned by the tables.
SYM_W, 9, symbol width returned by the tables.
RAW_W, 13, maximum raw-bit extraction count.
OUT_W, 13, result width; must be >= max(SYM_W, RAW_W).

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
data_in_vld  in  1  input word valid
data_in  in  IN_W  input word; bit IN_W-1 is the first bit of the stream
data_in_rdy  out  1  buffer can accept a word
cmd_vld  in  1  command valid
cmd_op  in  2  command: 0 = lit decode, 1 = dist decode, 2 = raw bits, 3 = byte align
cmd_nbits  in  ceilLog2(RAW_W+1)  bit count for raw command; ignored for other ops
cmd_rdy  out  1  command accepted when high together with cmd_vld
huff_addr  out  HUFF_CODE_LEN  buffer[BUF_W-1 -: HUFF_CODE_LEN]; drives both tables
lit_huff_len  in  HUFF_LEN_LEN  lit table code length; 0 = invalid code
lit_huff_sym  in  SYM_W  lit table symbol
dist_huff_len  in  HUFF_LEN_LEN  dist table code length; 0 = invalid code
dist_huff_sym  in  SYM_W  dist table symbol
data_out_vld  out  1  result valid
data_out  out  OUT_W  symbol, raw bits, or number of discarded bits; zero-extended
data_out_err  out  1  result is an invalid-code error
data_out_rdy  in  1  downstream ready
err  out  1  sticky error flag

Behaviour:
- Reset values: all outputs 0, except huff_addr (0, since buffer = 0). cmd_rdy is 1 the cycle after reset deasserts. buffer = 0, fill_cnt = 0, state IDLE.
- Buffer: valid bits are left-aligned at buffer[BUF_W-1]; bits below the fill point are always 0. fill_cnt ranges 0..BUF_W.
- data_in_rdy = (fill_cnt <= BUF_W-IN_W); it depends on registered state only. data_in_rdy is independent of the FSM state.
- Input fire in a cycle that consumes c bits:
  - buffer_next = (buffer << c) with data_in written at bits [BUF_W-1-(fill_cnt-c) -: IN_W].
  - fill_cnt_next = fill_cnt - c + IN_W.
- FSM: IDLE, EXEC, OUT.
  - IDLE: cmd_rdy = 1. On cmd_vld, latch op and nbits, go to EXEC.
  - EXEC: cmd_rdy = 0. Evaluate the latched op each cycle; when it resolves, register the result, consume its bits, go to OUT.
  - OUT: data_out_vld = 1, data_out and data_out_err held stable. On data_out_rdy, go to IDLE.
  - Minimum latency: cmd fire in cycle T -> data_out_vld in cycle T+2. One command completes per 3 cycles at most.
- Lit/dist decode, using len/sym from the selected table:
  - len != 0 and len <= fill_cnt: result = sym, consume len bits.
  - len == 0 and fill_cnt >= HUFF_CODE_LEN: data_out_err = 1, data_out = 0, consume 0 bits, set err.
  - Otherwise wait. A short final code resolves without padding because the zero fill below the fill point does not affect a prefix lookup.
- Raw: resolves when fill_cnt >= nbits. data_out = the top nbits of the buffer, MSB-first, zero-extended; consume nbits. nbits = 0 resolves immediately with data_out = 0.
- Align: discard k = fill_cnt mod 8 bits; data_out = k. k = 0 is legal and consumes nothing.
- err is sticky until rst. The block keeps accepting commands after an error; upstream decides whether to abort.
- Reset mid-operation: any state, any fill level -> IDLE, buffer and fill_cnt cleared. A pending result is dropped.
- Simultaneous input fire and consume: both apply in the same cycle. fill_cnt never exceeds BUF_W and never goes below 0.

Test Plan:
1. Raw fill: feed 0xA5, then 0x3C; cmd raw nbits=12 -> data_out=0xA53, fill_cnt=4; then raw nbits=4 -> 0xC.
2. Lit decode: table maps prefix 0b110 -> len=3, sym=0x105; stream byte 0xD0 -> data_out=0x105, fill_cnt 8->5. Repeat with a dist cmd to confirm dist_huff_* is selected.
3. Invalid code: lit table returns len=0, fill_cnt=16 -> data_out_vld with data_out_err=1, err stays 1, fill_cnt unchanged. A following raw cmd still completes.
4. Backpressure and full buffer:
   - hold data_out_rdy=0 for 10 cycles -> data_out stable; data_in_rdy drops once fill_cnt=32 (BUF_W=32).
   - release data_out_rdy -> next word accepted in the same cycle as a consume.
5. Align and end of stream:
   - after consuming 3 bits of one byte, cmd align -> data_out=5, fill_cnt=0.
   - a 2-bit final code with fill_cnt=2 and no more input -> resolves.
6. Reset mid-EXEC with fill_cnt=20 -> next cycle: state IDLE, cmd_rdy=1, data_out_vld=0, data_in_rdy=1, huff_addr=0, err=0.
